// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file geometry shared by the hazard, forwarding and register-file blocks
package cpu_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    function automatic int pend_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/hazard_pend_counter.sv
// hazard_pend_counter: loadable down-counter tracking one register's outstanding load, frozen on memory stall
module hazard_pend_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         freeze,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (!freeze && cnt != '0)
            cnt <= cnt - W'(1);
    end
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register pending-load scoreboard driving PC/IF-ID enables and ID/EX bubble
module hazard_scoreboard_unit
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
    parameter int LOAD_LAT   = 1,
    parameter int BR_EXTRA   = 1,
    parameter bit ZERO_REG   = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  ifid_uses_rs,
    input  logic                  ifid_uses_rt,
    input  logic [REG_ADDR_W-1:0] ifid_rd,
    input  logic                  id_memread,
    input  logic                  id_br,
    input  logic                  id_flush,
    input  logic                  idex_regwrite,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  mem_stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  controls_clear,
    output logic [CNT_W-1:0]      stall_count
);
    localparam int PW = pend_w(LOAD_LAT + BR_EXTRA);
    localparam int NR = 2 ** REG_ADDR_W;
    localparam logic [PW-1:0] SET_V = PW'(LOAD_LAT + BR_EXTRA);
    localparam logic [PW-1:0] BR_V  = PW'(BR_EXTRA);

    logic [PW-1:0] pend [NR];
    logic hz_rs, hz_rt, hz, issue, bubble;

    function automatic logic src_hz(input logic [REG_ADDR_W-1:0] s, input logic [PW-1:0] p);
        return !(ZERO_REG && s == '0) &&
               ((p > BR_V) || (id_br && p != '0) ||
                (id_br && idex_regwrite && !idex_memread && idex_rd == s));
    endfunction

    // Out-of-range and hardwired-zero slots are tied to 0 so every index reads a defined value
    for (genvar g = 0; g < NR; g++) begin : g_pend
        if (g < NUM_REGS && !(ZERO_REG && g == 0)) begin : g_cnt
            hazard_pend_counter #(.W(PW)) u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (issue && ifid_rd == REG_ADDR_W'(g)),
                .load_val (SET_V),
                .freeze   (mem_stall),
                .cnt      (pend[g])
            );
        end else begin : g_zero
            assign pend[g] = '0;
        end
    end

    assign hz_rs  = ifid_uses_rs && src_hz(ifid_rs, pend[ifid_rs]);
    assign hz_rt  = ifid_uses_rt && src_hz(ifid_rt, pend[ifid_rt]);
    assign hz     = hz_rs || hz_rt;
    assign issue  = rst_n && id_memread && !hz && !mem_stall && !id_flush;
    assign bubble = rst_n && !mem_stall && !id_flush && hz;

    assign pc_write       = rst_n && !mem_stall && !bubble;
    assign ifid_write     = rst_n && !mem_stall && !bubble;
    assign controls_clear = !rst_n || bubble;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_count <= '0;
        else if (bubble && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed plus random stimulus against a due-time reference model, two configurations
module tb_hazard_scoreboard_unit;
    localparam int LOAD_LAT = 1;
    localparam int BR_EXTRA = 1;

    logic clk, rst_n;
    logic [3:0] ifid_rs, ifid_rt, ifid_rd, idex_rd;
    logic ifid_uses_rs, ifid_uses_rt, id_memread, id_br, id_flush;
    logic idex_regwrite, idex_memread, mem_stall;
    logic [1:0] pcw, ifw, clr;
    logic [15:0] sc0;
    logic [3:0] sc1;

    int n_checks = 0;
    int n_errors = 0;
    int act = 0;
    int due [2][16];
    int cnt [2];
    int cmax [2] = '{65535, 15};

    hazard_scoreboard_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt), .ifid_rd(ifid_rd),
        .id_memread(id_memread), .id_br(id_br), .id_flush(id_flush),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .mem_stall(mem_stall), .pc_write(pcw[0]), .ifid_write(ifw[0]),
        .controls_clear(clr[0]), .stall_count(sc0)
    );

    hazard_scoreboard_unit #(.ZERO_REG(1'b1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt), .ifid_rd(ifid_rd),
        .id_memread(id_memread), .id_br(id_br), .id_flush(id_flush),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .mem_stall(mem_stall), .pc_write(pcw[1]), .ifid_write(ifw[1]),
        .controls_clear(clr[1]), .stall_count(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A load's result is usable by an ALU op once at most BR_EXTRA frozen-free cycles remain, by a branch once none remain
    function automatic logic m_src(input int k, input logic [3:0] s);
        int rem = (due[k][s] > act) ? due[k][s] - act : 0;
        if (k == 1 && s == 4'd0) return 1'b0;
        return rem > BR_EXTRA || (id_br && rem > 0) ||
               (id_br && idex_regwrite && !idex_memread && idex_rd == s);
    endfunction

    task automatic cyc(input logic rn, ms, fl, mr, br, ur, ut,
                       input logic [3:0] rs, rt, rd,
                       input logic xw, xm, input logic [3:0] xrd);
        logic h [2];
        logic [2:0] exp;
        rst_n = rn; mem_stall = ms; id_flush = fl; id_memread = mr; id_br = br;
        ifid_uses_rs = ur; ifid_uses_rt = ut; ifid_rs = rs; ifid_rt = rt; ifid_rd = rd;
        idex_regwrite = xw; idex_memread = xm; idex_rd = xrd;
        #1;
        for (int k = 0; k < 2; k++) begin
            h[k] = (ur && m_src(k, rs)) || (ut && m_src(k, rt));
            exp = !rn ? 3'b001 : ms ? 3'b000 : fl ? 3'b110 : h[k] ? 3'b001 : 3'b110;
            check($sformatf("ctl%0d", k), {29'd0, pcw[k], ifw[k], clr[k]}, {29'd0, exp});
            check($sformatf("cnt%0d", k), (k == 0) ? {16'd0, sc0} : {28'd0, sc1}, cnt[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rn) begin
                for (int r = 0; r < 16; r++) due[k][r] = 0;
                cnt[k] = 0;
            end else begin
                if (!ms && !fl && h[k]) cnt[k] = (cnt[k] + 1 > cmax[k]) ? cmax[k] : cnt[k] + 1;
                if (mr && !h[k] && !ms && !fl && !(k == 1 && rd == 4'd0))
                    due[k][rd] = act + 1 + LOAD_LAT + BR_EXTRA;
            end
        end
        if (!ms) act++;
        #1;
    endtask

    task automatic op(input logic mr, br, ur, input logic [3:0] rs, rd,
                      input logic ms = 1'b0, input logic fl = 1'b0);
        cyc(1'b1, ms, fl, mr, br, ur, 1'b0, rs, 4'd0, rd, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 16; r++) due[k][r] = 0;
            cnt[k] = 0;
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
        // load then dependent ALU op: one bubble
        op(1, 0, 0, 0, 3);
        op(0, 0, 1, 3, 0);
        op(0, 0, 1, 3, 0);
        check("lw_alu_cnt", {16'd0, sc0}, 1);
        // load then dependent branch: two bubbles
        op(1, 0, 0, 0, 5);
        repeat (3) op(0, 1, 1, 5, 0);
        check("lw_br_cnt", {16'd0, sc0}, 3);
        // ALU result in EX feeding a branch, then the same without the branch
        cyc(1, 0, 0, 0, 1, 0, 1, 4'd0, 4'd2, 4'd0, 1, 0, 4'd2);
        cyc(1, 0, 0, 0, 0, 0, 1, 4'd0, 4'd2, 4'd0, 1, 0, 4'd2);
        check("alu_br_cnt", {16'd0, sc0}, 4);
        // memory stall freezes the scoreboard
        op(1, 0, 0, 0, 4);
        repeat (3) op(0, 0, 1, 4, 0, 1'b1);
        repeat (2) op(0, 0, 1, 4, 0);
        check("mstall_cnt", {16'd0, sc0}, 5);
        // flush overrides the hazard, reset clears pending loads
        op(1, 0, 0, 0, 6);
        op(0, 0, 1, 6, 0, 1'b0, 1'b1);
        check("flush_cnt", {16'd0, sc0}, 5);
        op(1, 0, 0, 0, 6);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
        op(0, 0, 1, 6, 0);
        check("rst_cnt", {16'd0, sc0}, 0);
        // r0 loads only tracked when it is not hardwired
        op(1, 0, 0, 0, 0);
        op(0, 0, 1, 0, 0);
        // persistent forwarding hazard saturates the narrow counter
        repeat (20) cyc(1, 0, 0, 0, 1, 1, 0, 4'd2, 4'd0, 4'd0, 1, 0, 4'd2);
        check("sat_cnt1", {28'd0, sc1}, 15);
        check("sat_cnt0", {16'd0, sc0}, 21);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) < 2, $urandom_range(0, 9) < 3,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 7)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
